// File: rtl/priority_pkg.sv
// +----------------------------------------------------------------------+
// | priority_pkg : shared types and defaults for the request scheduler    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package priority_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } sched_state_e;

endpackage : priority_pkg

`default_nettype wire

// File: rtl/priority_encoder.sv
// +----------------------------------------------------------------------+
// | priority_encoder : index of the highest set bit of a request vector   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module priority_encoder #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o = IDXW'(i);
      end
    end
  end

endmodule : priority_encoder

`default_nettype wire

// File: rtl/priority_request_scheduler.sv
// +----------------------------------------------------------------------+
// | priority_request_scheduler : pending-request collector with a fixed   |
// | priority valid/ready grant port (bit N-1 highest).  Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module priority_request_scheduler #(
  parameter int N    = priority_pkg::DEFAULT_N,
  parameter int IDXW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_pulse,
  input  logic                   flush,
  output logic                   grant_valid,
  output logic [IDXW-1:0]        grant_idx,
  output logic [N-1:0]           grant_onehot,
  input  logic                   grant_ready,
  output logic [N-1:0]           pending,
  output logic [$clog2(N+1)-1:0] pending_count,
  output logic                   dup_req
);

  import priority_pkg::*;

  localparam int CNTW = $clog2(N+1);

  sched_state_e    state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic            dup_q, dup_d;

  logic            accept;
  logic [N-1:0]    accepted_bit;
  logic [N-1:0]    enc_in;
  logic [IDXW-1:0] enc_idx;
  logic            enc_valid;

  // Pending update: a strobe on the bit being accepted wins over the clear.
  always_comb begin
    accept       = (state_q == OFFER) && grant_ready;
    accepted_bit = '0;
    if (accept) begin
      accepted_bit[grant_idx_q] = 1'b1;
    end
    pending_d = (pending_q & ~accepted_bit) | req_pulse;
    dup_d     = |(req_pulse & pending_q & ~accepted_bit);
    if (flush) begin
      pending_d = '0;
      dup_d     = 1'b0;
    end
  end

  // IDLE looks at the registered vector (2-cycle latency); OFFER looks ahead
  // at the next vector so an accept can reload without a bubble.
  assign enc_in = (state_q == IDLE) ? pending_q : pending_d;

  priority_encoder #(
    .N    (N),
    .IDXW (IDXW)
  ) u_prio_enc (
    .req_i   (enc_in),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    unique case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d     = OFFER;
          grant_idx_d = enc_idx;
        end
      end
      OFFER: begin
        if (accept) begin
          if (enc_valid) begin
            grant_idx_d = enc_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      grant_idx_d = grant_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      grant_idx_q <= '0;
      dup_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      grant_idx_q <= grant_idx_d;
      dup_q       <= dup_d;
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < N; i++) begin
      grant_onehot[i] = (state_q == OFFER) && (grant_idx_q == IDXW'(i));
    end
  end

  always_comb begin
    pending_count = '0;
    for (int i = 0; i < N; i++) begin
      pending_count = pending_count + CNTW'(pending_q[i]);
    end
  end

  assign grant_valid = (state_q == OFFER);
  assign grant_idx   = grant_idx_q;
  assign pending     = pending_q;
  assign dup_req     = dup_q;

endmodule : priority_request_scheduler

`default_nettype wire

// File: tb/tb_priority_request_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_priority_request_scheduler : directed table bench for the          |
// | scheduler.  Rev 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_priority_request_scheduler;

  localparam int N    = 8;
  localparam int IDXW = 3;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_pulse;
  logic            flush;
  logic            grant_ready;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic [N-1:0]    grant_onehot;
  logic [N-1:0]    pending;
  logic [CNTW-1:0] pending_count;
  logic            dup_req;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0]    req;
    logic            flush;
    logic            ready;
    logic            valid;
    logic [IDXW-1:0] idx;
    logic [N-1:0]    onehot;
    logic [N-1:0]    pend;
    logic [CNTW-1:0] cnt;
    logic            dup;
  } vec_t;

  vec_t vecs[$];

  priority_request_scheduler #(
    .N    (N),
    .IDXW (IDXW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_pulse     (req_pulse),
    .flush         (flush),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .grant_onehot  (grant_onehot),
    .grant_ready   (grant_ready),
    .pending       (pending),
    .pending_count (pending_count),
    .dup_req       (dup_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, "_valid"},  32'(grant_valid),   32'(v.valid));
    check({tag, "_onehot"}, 32'(grant_onehot),  32'(v.onehot));
    check({tag, "_pend"},   32'(pending),       32'(v.pend));
    check({tag, "_cnt"},    32'(pending_count), 32'(v.cnt));
    check({tag, "_dup"},    32'(dup_req),       32'(v.dup));
    if (v.valid) begin
      check({tag, "_idx"}, 32'(grant_idx), 32'(v.idx));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    //                 req    fl    rdy  | valid idx   onehot  pend   cnt   dup
    // single request, latency 2, grant_ready ignored in IDLE
    vecs.push_back(vec_t'{8'h08, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h08, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 8'h08, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0});
    // priority and back-to-back 7,5,4
    vecs.push_back(vec_t'{8'hB0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hB0, 4'd3, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 8'hB0, 4'd3, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h80, 8'hB0, 4'd3, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 8'h30, 4'd2, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 8'h10, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0});
    // offer stays on 3 while a higher request arrives
    vecs.push_back(vec_t'{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h08, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 8'h08, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h80, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 8'h88, 4'd2, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 8'h88, 4'd2, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 8'h80, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0});
    // accept plus re-request of the same bit, then duplicate strobe on bit 5
    vecs.push_back(vec_t'{8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h04, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 8'h04, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h04, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 8'h04, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h20, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 8'h24, 4'd2, 1'b0});
    vecs.push_back(vec_t'{8'h20, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 8'h24, 4'd2, 1'b1});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 8'h24, 4'd2, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 8'h20, 4'd1, 1'b0});
    // flush mid-offer with a simultaneous strobe; nothing follows
    vecs.push_back(vec_t'{8'h01, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0});
    // flush masks a duplicate strobe and cancels the pending IDLE->OFFER move
    vecs.push_back(vec_t'{8'h02, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h02, 4'd1, 1'b0});
    vecs.push_back(vec_t'{8'h02, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0});
    vecs.push_back(vec_t'{8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b0});

    // reset held 2 cycles with all strobes active
    rst = 1'b1; req_pulse = 8'hFF; flush = 1'b0; grant_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst%0d_valid", c), 32'(grant_valid), 32'd0);
      check($sformatf("rst%0d_pend", c),  32'(pending), 32'd0);
      check($sformatf("rst%0d_cnt", c),   32'(pending_count), 32'd0);
      check($sformatf("rst%0d_dup", c),   32'(dup_req), 32'd0);
      check($sformatf("rst%0d_oh", c),    32'(grant_onehot), 32'd0);
      check($sformatf("rst%0d_idx", c),   32'(grant_idx), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; req_pulse = '0; grant_ready = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      req_pulse   = vecs[i].req;
      flush       = vecs[i].flush;
      grant_ready = vecs[i].ready;
      @(posedge clk); #1;
      check_all($sformatf("v%0d", i), vecs[i]);
    end

    // bounded latency measurement from a single strobe on bit 6
    @(negedge clk);
    req_pulse = 8'h40; flush = 1'b0; grant_ready = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    @(negedge clk);
    req_pulse = '0;
    while (!grant_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat_cycles", 32'(lat), 32'd2);
    check("lat_idx", 32'(grant_idx), 32'd6);
    check("lat_onehot", 32'(grant_onehot), 32'h40);

    // reset aborts the offer even with ready, strobes and flush active
    @(negedge clk);
    rst = 1'b1; grant_ready = 1'b1; req_pulse = 8'hFF; flush = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 32'(grant_valid), 32'd0);
    check("abort_pend", 32'(pending), 32'd0);
    check("abort_idx", 32'(grant_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0; grant_ready = 1'b0; req_pulse = '0; flush = 1'b0;
    @(posedge clk); #1;
    check("post_abort_valid", 32'(grant_valid), 32'd0);
    check("post_abort_cnt", 32'(pending_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_priority_request_scheduler

`default_nettype wire

// File: doc/priority_request_scheduler.md
PRIORITY_REQUEST_SCHEDULER -- requirements
Module: priority_request_scheduler

Interface
REQ-001 SHALL have parameter N, default 8: number of request lines, N >= 2.
REQ-002 SHALL have parameter IDXW, default $clog2(N): width of the grant index.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req_pulse, input, N bits: one-cycle request strobes; bit i sets pending bit i.
REQ-006 SHALL have port flush, input, 1 bit: clears all pending requests and the current offer.
REQ-007 SHALL have port grant_valid, output, 1 bit: a grant is offered.
REQ-008 SHALL have port grant_idx, output, IDXW bits: index of the offered request.
REQ-009 SHALL have port grant_onehot, output, N bits: one-hot decode of grant_idx, all-zero when grant_valid=0.
REQ-010 SHALL have port grant_ready, input, 1 bit: consumer accepts the offer.
REQ-011 SHALL have port pending, output, N bits: registered pending-request vector.
REQ-012 SHALL have port pending_count, output, $clog2(N+1) bits: popcount of pending.
REQ-013 SHALL have port dup_req, output, 1 bit: registered one-cycle pulse when a strobe hits an already-pending bit.

Function
REQ-014 SHALL give bit N-1 the highest priority and bit 0 the lowest.
REQ-015 SHALL use a two-state FSM: IDLE (grant_valid=0) and OFFER (grant_valid=1).
REQ-016 SHALL update pending each edge as (pending & ~accepted_bit) | req_pulse; a set on the bit being accepted wins, so that bit stays pending.
REQ-017 SHALL, in IDLE with pending != 0, go to OFFER and register grant_idx = highest set bit of pending.
REQ-018 SHALL give a latency of exactly 2 cycles from a req_pulse edge (IDLE, empty) to grant_valid=1.
REQ-019 SHALL, in OFFER with grant_ready=0, hold grant_idx and grant_onehot stable, even when a higher-priority request arrives.
REQ-020 SHALL treat grant_valid & grant_ready as an accept, and clear pending[grant_idx] on that edge.
REQ-021 SHALL, on accept, stay in OFFER if the next pending value is nonzero, with grant_idx loaded from it (back-to-back, no bubble); otherwise go to IDLE.
REQ-022 SHALL ignore grant_ready while in IDLE.
REQ-023 SHALL, when flush=1, give pending=0 and FSM=IDLE on the next edge; flush overrides req_pulse and accept in that cycle.
REQ-024 SHALL set dup_req=1 for one cycle when any req_pulse bit is already pending and is not being accepted that cycle; dup_req SHALL be 0 when flush=1.
REQ-025 SHALL derive pending_count combinationally from the pending register; maximum value N.

Reset
REQ-026 SHALL, with rst=1, give on the next edge: FSM=IDLE, pending=0, grant_idx=0, grant_onehot=0, grant_valid=0, dup_req=0, pending_count=0.
REQ-027 SHALL give rst priority over flush, req_pulse and grant_ready, and SHALL abort an in-progress offer without an accept.

Structure
REQ-028 SHALL place the FSM state enum typedef (IDLE, OFFER) and the default N constant in shared package priority_pkg.
REQ-029 SHALL compute the highest-set-bit selection with one instance of the existing priority_encoder #(N).
REQ-030 SHALL implement the grant one-hot decode, popcount and FSM inline in this module.

Verification
REQ-031 Reset: hold rst=1 for 2 cycles with req_pulse=8'hFF -> grant_valid=0, pending=0, pending_count=0, dup_req=0.
REQ-032 Single request: req_pulse=8'b00001000 for 1 cycle with grant_ready=1 -> 2 cycles later grant_valid=1, grant_idx=3, grant_onehot=8'b00001000 for 1 cycle; then pending=0 and grant_valid=0.
REQ-033 Priority and back-to-back: req_pulse=8'b10110000 with grant_ready=0 for 3 cycles, then 1 -> grant_idx holds 7, then offers 7,5,4 on consecutive cycles, then grant_valid=0; pending_count steps 3,2,1,0.
REQ-034 Stability: offering idx 3 with grant_ready=0, req_pulse=8'b10000000 -> grant_idx stays 3 until accept; the next offer is idx 7.
REQ-035 Accept plus re-request: offering idx 2, grant_ready=1 and req_pulse=8'b00000100 in the same cycle -> next offer is idx 2 again, dup_req=0; a later strobe on pending bit 5 -> dup_req=1 for exactly 1 cycle.
REQ-036 Flush mid-offer: flush=1 together with req_pulse=8'b00000001 -> next cycle grant_valid=0, pending=0; no grant follows.
